// File: rtl/tilelink_reg_adapter.sv
// TL-UL slave endpoint: one Channel A request becomes one req/ack register access, answered on Channel D.
// Requests are protocol-checked before any register access; a stalled slave is cut off by a timer.
module tilelink_reg_adapter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MASK_WIDTH     = DATA_WIDTH / 8,
    parameter int OPCODE_WIDTH   = 3,
    parameter int PARAM_WIDTH    = 3,
    parameter int SIZE_WIDTH     = 3,
    parameter int SRC_WIDTH      = 2,
    parameter int SINK_WIDTH     = 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [OPCODE_WIDTH-1:0] a_opcode,
    input  logic [PARAM_WIDTH-1:0]  a_param,
    input  logic [SIZE_WIDTH-1:0]   a_size,
    input  logic [SRC_WIDTH-1:0]    a_source,
    input  logic [ADDR_WIDTH-1:0]   a_address,
    input  logic [MASK_WIDTH-1:0]   a_mask,
    input  logic [DATA_WIDTH-1:0]   a_data,
    output logic                    d_valid,
    input  logic                    d_ready,
    output logic [OPCODE_WIDTH-1:0] d_opcode,
    output logic [PARAM_WIDTH-1:0]  d_param,
    output logic [SIZE_WIDTH-1:0]   d_size,
    output logic [SRC_WIDTH-1:0]    d_source,
    output logic [SINK_WIDTH-1:0]   d_sink,
    output logic [DATA_WIDTH-1:0]   d_data,
    output logic                    d_error,
    output logic                    reg_req,
    output logic                    reg_we,
    output logic [ADDR_WIDTH-1:0]   reg_addr,
    output logic [MASK_WIDTH-1:0]   reg_be,
    output logic [DATA_WIDTH-1:0]   reg_wdata,
    input  logic                    reg_ack,
    input  logic [DATA_WIDTH-1:0]   reg_rdata,
    input  logic                    reg_err
);

    // state  | meaning
    // IDLE   | a_ready high, waiting for a Channel A request
    // CHECK  | one cycle of protocol checks on the latched request
    // ACCESS | reg_req held until reg_ack or timer terminal count
    // RESP   | d_valid held until d_ready
    typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_ACCESS, ST_RESP} state_t;

    localparam int OFF_W = $clog2(MASK_WIDTH);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [OPCODE_WIDTH-1:0] OP_PUT_FULL = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_PUT_PART = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_GET      = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_ACK      = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_ACK_DATA = OPCODE_WIDTH'(1);

    state_t                  state_q, state_d;
    logic                    a_ready_q, a_ready_d;
    logic [OPCODE_WIDTH-1:0] op_q, op_d;
    logic [PARAM_WIDTH-1:0]  param_q, param_d;
    logic [SIZE_WIDTH-1:0]   size_q, size_d;
    logic [SRC_WIDTH-1:0]    source_q, source_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [MASK_WIDTH-1:0]   mask_q, mask_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    d_valid_q, d_valid_d;
    logic [OPCODE_WIDTH-1:0] d_opcode_q, d_opcode_d;
    logic [SIZE_WIDTH-1:0]   d_size_q, d_size_d;
    logic [SRC_WIDTH-1:0]    d_source_q, d_source_d;
    logic [DATA_WIDTH-1:0]   d_data_q, d_data_d;
    logic                    d_error_q, d_error_d;
    logic                    reg_req_q, reg_req_d;
    logic                    reg_we_q, reg_we_d;
    logic [ADDR_WIDTH-1:0]   reg_addr_q, reg_addr_d;
    logic [MASK_WIDTH-1:0]   reg_be_q, reg_be_d;
    logic [DATA_WIDTH-1:0]   reg_wdata_q, reg_wdata_d;
    logic [TMR_W-1:0]        tmr_q, tmr_d;

    logic [7:0]            size_mask;
    logic [OFF_W-1:0]      al_mask;
    logic [OFF_W-1:0]      off;
    logic [MASK_WIDTH-1:0] lanes;
    logic                  check_fail;

    // Byte lanes covered by a naturally aligned access of 2^size bytes at the latched address.
    always_comb begin
        size_mask = (8'd1 << size_q) - 8'd1;
        al_mask   = size_mask[OFF_W-1:0];
        off       = addr_q[OFF_W-1:0];
        lanes     = '0;
        for (int i = 0; i < MASK_WIDTH; i++) begin
            lanes[i] = ((OFF_W'(i) & ~al_mask) == (off & ~al_mask));
        end
        check_fail = ((op_q != OP_PUT_FULL) && (op_q != OP_PUT_PART) && (op_q != OP_GET))
                   || (int'(size_q) > OFF_W)
                   || ((off & al_mask) != '0)
                   || ((mask_q & ~lanes) != '0)
                   || ((op_q == OP_PUT_FULL) && (mask_q != lanes))
                   || (param_q != '0);
    end

    always_comb begin
        state_d     = state_q;
        a_ready_d   = a_ready_q;
        op_d        = op_q;
        param_d     = param_q;
        size_d      = size_q;
        source_d    = source_q;
        addr_d      = addr_q;
        mask_d      = mask_q;
        data_d      = data_q;
        d_valid_d   = d_valid_q;
        d_opcode_d  = d_opcode_q;
        d_size_d    = d_size_q;
        d_source_d  = d_source_q;
        d_data_d    = d_data_q;
        d_error_d   = d_error_q;
        reg_req_d   = reg_req_q;
        reg_we_d    = reg_we_q;
        reg_addr_d  = reg_addr_q;
        reg_be_d    = reg_be_q;
        reg_wdata_d = reg_wdata_q;
        tmr_d       = tmr_q;
        case (state_q)
            ST_IDLE: begin
                if (a_valid) begin
                    op_d      = a_opcode;
                    param_d   = a_param;
                    size_d    = a_size;
                    source_d  = a_source;
                    addr_d    = a_address;
                    mask_d    = a_mask;
                    data_d    = a_data;
                    a_ready_d = 1'b0;
                    state_d   = ST_CHECK;
                end
            end
            ST_CHECK: begin
                d_opcode_d = (op_q == OP_GET) ? OP_ACK_DATA : OP_ACK;
                d_size_d   = size_q;
                d_source_d = source_q;
                if (check_fail) begin
                    d_valid_d = 1'b1;
                    d_error_d = 1'b1;
                    d_data_d  = '0;
                    state_d   = ST_RESP;
                end else begin
                    reg_req_d   = 1'b1;
                    reg_we_d    = (op_q != OP_GET);
                    reg_addr_d  = addr_q & ~ADDR_WIDTH'(MASK_WIDTH - 1);
                    reg_be_d    = (op_q == OP_GET) ? '1 : mask_q;
                    reg_wdata_d = data_q;
                    tmr_d       = TMR_W'(TIMEOUT_CYCLES - 1);
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // An ack on the terminal-count cycle still counts as a normal completion.
                if (reg_ack) begin
                    reg_req_d = 1'b0;
                    d_valid_d = 1'b1;
                    d_error_d = reg_err;
                    d_data_d  = (reg_err || (op_q != OP_GET)) ? '0 : reg_rdata;
                    state_d   = ST_RESP;
                end else if (tmr_q == '0) begin
                    reg_req_d = 1'b0;
                    d_valid_d = 1'b1;
                    d_error_d = 1'b1;
                    d_data_d  = '0;
                    state_d   = ST_RESP;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (d_ready) begin
                    d_valid_d = 1'b0;
                    a_ready_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            a_ready_q   <= 1'b1;
            op_q        <= '0;
            param_q     <= '0;
            size_q      <= '0;
            source_q    <= '0;
            addr_q      <= '0;
            mask_q      <= '0;
            data_q      <= '0;
            d_valid_q   <= 1'b0;
            d_opcode_q  <= '0;
            d_size_q    <= '0;
            d_source_q  <= '0;
            d_data_q    <= '0;
            d_error_q   <= 1'b0;
            reg_req_q   <= 1'b0;
            reg_we_q    <= 1'b0;
            reg_addr_q  <= '0;
            reg_be_q    <= '0;
            reg_wdata_q <= '0;
            tmr_q       <= '0;
        end else begin
            state_q     <= state_d;
            a_ready_q   <= a_ready_d;
            op_q        <= op_d;
            param_q     <= param_d;
            size_q      <= size_d;
            source_q    <= source_d;
            addr_q      <= addr_d;
            mask_q      <= mask_d;
            data_q      <= data_d;
            d_valid_q   <= d_valid_d;
            d_opcode_q  <= d_opcode_d;
            d_size_q    <= d_size_d;
            d_source_q  <= d_source_d;
            d_data_q    <= d_data_d;
            d_error_q   <= d_error_d;
            reg_req_q   <= reg_req_d;
            reg_we_q    <= reg_we_d;
            reg_addr_q  <= reg_addr_d;
            reg_be_q    <= reg_be_d;
            reg_wdata_q <= reg_wdata_d;
            tmr_q       <= tmr_d;
        end
    end

    assign a_ready   = a_ready_q;
    assign d_valid   = d_valid_q;
    assign d_opcode  = d_opcode_q;
    assign d_param   = '0;
    assign d_size    = d_size_q;
    assign d_source  = d_source_q;
    assign d_sink    = '0;
    assign d_data    = d_data_q;
    assign d_error   = d_error_q;
    assign reg_req   = reg_req_q;
    assign reg_we    = reg_we_q;
    assign reg_addr  = reg_addr_q;
    assign reg_be    = reg_be_q;
    assign reg_wdata = reg_wdata_q;

endmodule

// File: tb/tb_tilelink_reg_adapter.sv
// Bench for tilelink_reg_adapter: directed scenarios plus randomized requests against a byte-lane
// legality model and an emulated register slave with programmable ack delay.
module tb_tilelink_reg_adapter;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        a_valid, a_ready;
    logic [2:0]  a_opcode, a_param, a_size;
    logic [1:0]  a_source;
    logic [31:0] a_address, a_data;
    logic [3:0]  a_mask;
    logic        d_valid, d_ready;
    logic [2:0]  d_opcode, d_param, d_size;
    logic [1:0]  d_source;
    logic [0:0]  d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        reg_req, reg_we, reg_ack, reg_err;
    logic [31:0] reg_addr, reg_wdata, reg_rdata;
    logic [3:0]  reg_be;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tilelink_reg_adapter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size),
        .d_source(d_source), .d_sink(d_sink), .d_data(d_data), .d_error(d_error),
        .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_be(reg_be), .reg_wdata(reg_wdata),
        .reg_ack(reg_ack), .reg_rdata(reg_rdata), .reg_err(reg_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // A request is legal when its opcode is known, param is zero, and its bytes form a naturally
    // aligned run inside one word that contains every enabled lane (PutFull: exactly that run).
    function automatic bit model_legal(input int op, input int param, input int size,
                                       input logic [31:0] addr, input logic [3:0] mask);
        int bytes, off;
        bit inl;
        if (!(op == 0 || op == 1 || op == 4)) return 1'b0;
        if (param != 0 || size > 2) return 1'b0;
        bytes = 1 << size;
        off   = int'(addr[1:0]);
        if (off % bytes != 0) return 1'b0;
        for (int b = 0; b < 4; b++) begin
            inl = (b >= off) && (b < off + bytes);
            if (mask[b] && !inl) return 1'b0;
            if (op == 0 && (mask[b] != inl)) return 1'b0;
        end
        return 1'b1;
    endfunction

    // ack_k: cycle of reg_req (1-based) on which the slave acks; 0 = never.
    task automatic run_txn(input int op, input int param, input int size, input int src,
                           input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] wdata,
                           input int ack_k, input logic [31:0] rdata, input bit err,
                           input int stall, input bit spurious);
        bit          legal, exp_err, seen;
        int          exp_req, exp_lat, t, req_cnt;
        logic [31:0] exp_data;
        legal    = model_legal(op, param, size, addr, mask);
        exp_req  = !legal ? 0 : (ack_k == 0 || ack_k > TMO) ? TMO : ack_k;
        exp_lat  = 2 + exp_req;
        exp_err  = !legal || ack_k == 0 || ack_k > TMO || err;
        exp_data = (!exp_err && op == 4) ? rdata : 32'h0;

        chk("a_ready_idle", a_ready, 1);
        a_valid   = 1'b1;
        a_opcode  = 3'(op);
        a_param   = 3'(param);
        a_size    = 3'(size);
        a_source  = 2'(src);
        a_address = addr;
        a_mask    = mask;
        a_data    = wdata;
        reg_ack   = spurious;
        @(posedge clk);
        @(negedge clk);
        a_valid   = 1'b0;
        a_address = $urandom;
        a_data    = $urandom;
        a_mask    = 4'($urandom);
        t = 1;
        req_cnt = 0;
        seen = 1'b0;
        while (t < 40 && !seen) begin
            if (d_valid) begin
                seen = 1'b1;
            end else begin
                if (reg_req) begin
                    req_cnt++;
                    chk("reg_addr", reg_addr, addr & 32'hFFFF_FFFC);
                    chk("reg_be", reg_be, (op == 4) ? 4'hF : mask);
                    chk("reg_we", reg_we, (op != 4));
                    if (op != 4) chk("reg_wdata", reg_wdata, wdata);
                    reg_ack   = (req_cnt == ack_k);
                    reg_rdata = (req_cnt == ack_k) ? rdata : $urandom;
                    reg_err   = (req_cnt == ack_k) ? err : 1'($urandom);
                end else begin
                    reg_ack = (t == 1) ? spurious : 1'b0;
                    reg_err = 1'($urandom);
                end
                @(posedge clk);
                @(negedge clk);
                t++;
            end
        end
        reg_ack = 1'b0;
        chk("resp_seen", seen, 1);
        chk("latency", t, exp_lat);
        chk("req_cycles", req_cnt, exp_req);
        chk("req_dropped", reg_req, 0);
        for (int s = 0; s <= stall; s++) begin
            chk("d_valid", d_valid, 1);
            chk("d_error", d_error, exp_err);
            chk("d_data", d_data, exp_data);
            chk("d_source", d_source, src);
            chk("d_size", d_size, size);
            chk("d_param_sink", {d_param, d_sink}, 0);
            chk("a_ready_resp", a_ready, 0);
            if (op == 0 || op == 1 || op == 4) chk("d_opcode", d_opcode, (op == 4) ? 1 : 0);
            if (s < stall) begin
                reg_ack = 1'($urandom);
                @(posedge clk);
                @(negedge clk);
                reg_ack = 1'b0;
            end
        end
        d_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        d_ready = 1'b0;
        chk("d_valid_drop", d_valid, 0);
    endtask

    initial begin
        int op, sz, k, pick;
        logic [31:0] ad;
        logic [3:0]  mk, ln;
        reset_n = 1'b0;
        a_valid = 1'b0; a_opcode = '0; a_param = '0; a_size = '0; a_source = '0;
        a_address = '0; a_mask = '0; a_data = '0;
        d_ready = 1'b0; reg_ack = 1'b0; reg_rdata = '0; reg_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_a_ready", a_ready, 1);
        chk("rst_d_valid", d_valid, 0);
        chk("rst_reg_req", reg_req, 0);
        chk("rst_payload", {d_data, reg_addr, reg_wdata, reg_be, reg_we, d_error}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        run_txn(4, 0, 2, 1, 32'h10, 4'hF, 32'h0, 3, 32'hDEADBEEF, 0, 0, 0);
        run_txn(1, 0, 1, 2, 32'h22, 4'hC, 32'hABCD0000, 1, 32'h1234, 0, 0, 0);
        run_txn(4, 0, 2, 0, 32'h13, 4'hF, 32'h0, 1, 32'h5555, 0, 0, 0);
        run_txn(5, 0, 2, 3, 32'h40, 4'hF, 32'h0, 1, 32'h5555, 0, 0, 0);
        run_txn(4, 0, 2, 1, 32'h44, 4'hF, 32'h0, 0, 32'h7777, 0, 0, 0);
        run_txn(4, 0, 2, 2, 32'h48, 4'hF, 32'h0, TMO, 32'hCAFEF00D, 0, 0, 0);
        run_txn(0, 0, 2, 1, 32'h50, 4'hF, 32'h11223344, 2, 32'h0, 1, 0, 1);
        run_txn(0, 0, 1, 1, 32'h52, 4'h4, 32'h0, 1, 32'h0, 0, 0, 0);
        run_txn(4, 1, 2, 1, 32'h60, 4'hF, 32'h0, 1, 32'h0, 0, 0, 0);
        run_txn(4, 0, 2, 3, 32'h64, 4'hF, 32'h0, 2, 32'hA5A5A5A5, 0, 5, 0);
        run_txn(4, 0, 2, 0, 32'h68, 4'hF, 32'h0, 1, 32'h01020304, 0, 0, 0);
        run_txn(4, 0, 0, 1, 32'h6B, 4'h8, 32'h0, 1, 32'h0A0B0C0D, 0, 0, 0);

        // Abort during ACCESS via asynchronous reset.
        a_valid = 1'b1; a_opcode = 3'd4; a_param = '0; a_size = 3'd2; a_source = 2'd1;
        a_address = 32'h80; a_mask = 4'hF;
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #2;
        chk("abort_req_before", reg_req, 1);
        reset_n = 1'b0;
        #1;
        chk("abort_reg_req", reg_req, 0);
        chk("abort_d_valid", d_valid, 0);
        chk("abort_a_ready", a_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_abort_idle", {a_ready, d_valid, reg_req}, 3'b100);
        run_txn(4, 0, 2, 2, 32'h84, 4'hF, 32'h0, 1, 32'h600DF00D, 0, 0, 0);

        for (int n = 0; n < 150; n++) begin
            pick = $urandom_range(0, 9);
            op = (pick < 3) ? 0 : (pick < 6) ? 1 : (pick < 9) ? 4 : $urandom_range(0, 7);
            sz = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            ad = $urandom;
            if ($urandom_range(0, 4) != 0) ad[1:0] = 2'(ad[1:0] & ~2'((1 << (sz > 2 ? 2 : sz)) - 1));
            ln = 4'((1 << (1 << (sz > 2 ? 2 : sz))) - 1) << ad[1:0];
            mk = (op == 1) ? (ln & 4'($urandom)) : ln;
            if ($urandom_range(0, 7) == 0) mk = 4'($urandom);
            k = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TMO);
            if (k > 6 && $urandom_range(0, 2) != 0) k = $urandom_range(1, 4);
            run_txn(op, ($urandom_range(0, 15) == 0) ? 1 : 0, sz, $urandom_range(0, 3), ad, mk, $urandom,
                    k, $urandom, ($urandom_range(0, 7) == 0), $urandom_range(0, 3), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
